// File: rtl/sum_window_stats_if.sv
// Sample and result handshake bundle between the adder stage, the window
// statistics block and its downstream consumer.
interface sum_window_stats_if #(
  parameter int SUM_W = 10,
  parameter int CNT_W = 5,
  parameter int ACC_W = 14
) ();
  logic             in_vld;
  logic             in_rdy;
  logic [SUM_W-1:0] in_sum;
  logic             in_zero;
  logic             in_flush;
  logic             out_vld;
  logic             out_rdy;
  logic [ACC_W-1:0] out_acc;
  logic [SUM_W-1:0] out_max;
  logic [CNT_W-1:0] out_zeros;
  logic [CNT_W-1:0] out_run;
  logic [CNT_W-1:0] out_cnt;
  logic             err_zero;

  modport master (
    output in_vld, in_sum, in_zero, in_flush, out_rdy,
    input  in_rdy, out_vld, out_acc, out_max, out_zeros, out_run, out_cnt, err_zero
  );

  modport slave (
    input  in_vld, in_sum, in_zero, in_flush, out_rdy,
    output in_rdy, out_vld, out_acc, out_max, out_zeros, out_run, out_cnt, err_zero
  );
endinterface

// File: rtl/sum_window_stats.sv
// Windowed statistics over the registered adder sum: total, max, zero count,
// longest zero run and sample count, presented on a held valid/ready port.
module sum_window_stats #(
  parameter int SUM_W = 10,
  parameter int WIN   = 16,
  parameter int CNT_W = 5,
  parameter int ACC_W = 14
) (
  input  logic              clk,
  input  logic              rst,
  sum_window_stats_if.slave bus
);

  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(WIN - 1);

  typedef enum logic [0:0] {
    ST_ACCUM = 1'b0,
    ST_HOLD  = 1'b1
  } state_t;

  function automatic logic [SUM_W-1:0] max_sum(input logic [SUM_W-1:0] a,
                                               input logic [SUM_W-1:0] b);
    return (b > a) ? b : a;
  endfunction

  function automatic logic zero_flag_bad(input logic [SUM_W-1:0] sum,
                                         input logic             zero);
    return zero != (sum == {SUM_W{1'b0}});
  endfunction

  state_t           state_r, state_nx_s;
  logic [ACC_W-1:0] acc_r, acc_s;
  logic [SUM_W-1:0] max_r, max_s;
  logic [CNT_W-1:0] zeros_r, zeros_s;
  logic [CNT_W-1:0] run_r, run_s;
  logic [CNT_W-1:0] run_max_r, run_max_s;
  logic [CNT_W-1:0] cnt_r, cnt_s;
  logic [ACC_W-1:0] out_acc_r;
  logic [SUM_W-1:0] out_max_r;
  logic [CNT_W-1:0] out_zeros_r;
  logic [CNT_W-1:0] out_run_r;
  logic [CNT_W-1:0] out_cnt_r;
  logic             err_zero_r;
  logic             out_vld_s;
  logic             in_rdy_s;
  logic             accept_s;
  logic             consume_s;
  logic             close_s;

  // Handshake decode; in HOLD a sample slips in only alongside a consume.
  always_comb begin
    out_vld_s = (state_r == ST_HOLD);
    in_rdy_s  = (state_r == ST_ACCUM) | (out_vld_s & bus.out_rdy);
    accept_s  = bus.in_vld & in_rdy_s;
    consume_s = out_vld_s & bus.out_rdy;
    close_s   = (accept_s & (cnt_r == LAST_IDX))
              | (bus.in_flush & ((cnt_r != {CNT_W{1'b0}}) | accept_s));
  end

  // Working statistics including this cycle's sample.
  always_comb begin
    acc_s     = acc_r;
    max_s     = max_r;
    zeros_s   = zeros_r;
    run_s     = run_r;
    run_max_s = run_max_r;
    cnt_s     = cnt_r;
    if (accept_s) begin
      acc_s = acc_r + ACC_W'(bus.in_sum);
      max_s = max_sum(max_r, bus.in_sum);
      cnt_s = cnt_r + CNT_W'(1);
      if (bus.in_zero) begin
        zeros_s = zeros_r + CNT_W'(1);
        run_s   = run_r + CNT_W'(1);
      end else begin
        zeros_s = zeros_r;
        run_s   = {CNT_W{1'b0}};
      end
      run_max_s = (run_s > run_max_r) ? run_s : run_max_r;
    end else begin
      cnt_s = cnt_r;
    end
  end

  // Next-state logic; a close always lands in HOLD, even straight out of HOLD.
  always_comb begin
    state_nx_s = state_r;
    case (state_r)
      ST_ACCUM: begin
        if (close_s) begin
          state_nx_s = ST_HOLD;
        end else begin
          state_nx_s = ST_ACCUM;
        end
      end
      ST_HOLD: begin
        if (close_s) begin
          state_nx_s = ST_HOLD;
        end else if (consume_s) begin
          state_nx_s = ST_ACCUM;
        end else begin
          state_nx_s = ST_HOLD;
        end
      end
      default: state_nx_s = ST_ACCUM;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= ST_ACCUM;
    end else begin
      state_r <= state_nx_s;
    end
  end

  // Working statistics register, cleared whenever a window closes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_r     <= {ACC_W{1'b0}};
      max_r     <= {SUM_W{1'b0}};
      zeros_r   <= {CNT_W{1'b0}};
      run_r     <= {CNT_W{1'b0}};
      run_max_r <= {CNT_W{1'b0}};
      cnt_r     <= {CNT_W{1'b0}};
    end else if (close_s) begin
      acc_r     <= {ACC_W{1'b0}};
      max_r     <= {SUM_W{1'b0}};
      zeros_r   <= {CNT_W{1'b0}};
      run_r     <= {CNT_W{1'b0}};
      run_max_r <= {CNT_W{1'b0}};
      cnt_r     <= {CNT_W{1'b0}};
    end else begin
      acc_r     <= acc_s;
      max_r     <= max_s;
      zeros_r   <= zeros_s;
      run_r     <= run_s;
      run_max_r <= run_max_s;
      cnt_r     <= cnt_s;
    end
  end

  // Result registers, loaded only on close so they hold while unaccepted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_acc_r   <= {ACC_W{1'b0}};
      out_max_r   <= {SUM_W{1'b0}};
      out_zeros_r <= {CNT_W{1'b0}};
      out_run_r   <= {CNT_W{1'b0}};
      out_cnt_r   <= {CNT_W{1'b0}};
    end else if (close_s) begin
      out_acc_r   <= acc_s;
      out_max_r   <= max_s;
      out_zeros_r <= zeros_s;
      out_run_r   <= run_max_s;
      out_cnt_r   <= cnt_s;
    end else begin
      out_acc_r   <= out_acc_r;
      out_max_r   <= out_max_r;
      out_zeros_r <= out_zeros_r;
      out_run_r   <= out_run_r;
      out_cnt_r   <= out_cnt_r;
    end
  end

  // Sticky flag for a zero flag that contradicts its sum.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_zero_r <= 1'b0;
    end else if (accept_s && zero_flag_bad(bus.in_sum, bus.in_zero)) begin
      err_zero_r <= 1'b1;
    end else begin
      err_zero_r <= err_zero_r;
    end
  end

  assign bus.in_rdy    = in_rdy_s;
  assign bus.out_vld   = out_vld_s;
  assign bus.out_acc   = out_acc_r;
  assign bus.out_max   = out_max_r;
  assign bus.out_zeros = out_zeros_r;
  assign bus.out_run   = out_run_r;
  assign bus.out_cnt   = out_cnt_r;
  assign bus.err_zero  = err_zero_r;

endmodule
